stream_mux: RTL

//  Parametrised N-way registered channel multiplexer with valid/ready handshake; successor to the 4-bit 2:1 combinational mux.

---
 rtl/stream_mux.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stream_mux.sv
// stream_mux: N-way registered channel multiplexer with valid/ready handshake and glitch-free switching.
// Optional starvation failsafe enabled by defining STREAM_MUX_FAILSAFE_EN.
`default_nettype none

module stream_mux #(
  parameter int WIDTH       = 4,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_SEL = 0,
  parameter int TIMEOUT     = 1000,
  parameter int FAILSAFE_CH = 0,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]       valid_i,
  output logic [NUM_CH-1:0]       ready_o,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [SEL_W-1:0]        active_sel_o,
  output logic                    sel_err_o,
  output logic                    fault_o
);

  localparam logic [SEL_W:0]   NUM_CH_W = NUM_CH[SEL_W:0];
  localparam logic [SEL_W-1:0] DEF_SEL  = DEFAULT_SEL[SEL_W-1:0];

  logic [WIDTH-1:0] ch_data [NUM_CH];
  logic             load_en;
  logic             sel_bad;
  logic             switch_req;
  logic             take;
  logic             do_switch;
  logic             valid_act;
  logic             timeout;
  logic             fault_gate;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_data[k] = data_i[k*WIDTH +: WIDTH];
  end

  assign load_en    = !valid_o | ready_i;
  assign sel_bad    = {1'b0, sel_i} >= NUM_CH_W;
  assign valid_act  = valid_i[active_sel_o];
  // While the failsafe holds the mux, only a request for the failsafe channel is honoured.
  assign switch_req = (sel_i != active_sel_o) & !sel_bad & fault_gate;
  assign do_switch  = switch_req & load_en;
  assign take       = valid_act & load_en & !switch_req;

  always_comb begin
    ready_o               = '0;
    ready_o[active_sel_o] = load_en & !switch_req;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      active_sel_o <= DEF_SEL;
      sel_err_o    <= 1'b0;
    end else begin
      sel_err_o <= sel_bad;
      if (load_en) begin
        if (take) begin
          data_o  <= ch_data[active_sel_o];
          valid_o <= 1'b1;
        end else begin
          valid_o <= 1'b0;
        end
      end
      if (timeout) begin
        active_sel_o <= FAILSAFE_CH[SEL_W-1:0];
      end else if (do_switch) begin
        active_sel_o <= sel_i;
      end
    end
  end

`ifdef STREAM_MUX_FAILSAFE_EN
  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] FS_SEL   = FAILSAFE_CH[SEL_W-1:0];

  logic [CNT_W-1:0] starve_cnt;
  logic             on_fs;

  assign on_fs      = (active_sel_o == FS_SEL);
  assign fault_gate = !fault_o | (sel_i == FS_SEL);
  assign timeout    = !fault_o & !on_fs & !valid_act & (starve_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
      fault_o    <= 1'b0;
    end else begin
      if (timeout) begin
        fault_o <= 1'b1;
      end else if (fault_o && (sel_i == FS_SEL)) begin
        fault_o <= 1'b0;
      end
      if (timeout | take | do_switch | on_fs) begin
        starve_cnt <= '0;
      end else if (!valid_act && !fault_o) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_failsafe_params;

  assign fault_gate             = 1'b1;
  assign timeout                = 1'b0;
  assign unused_failsafe_params = (TIMEOUT != 0) ^ (FAILSAFE_CH != 0);

  always_ff @(posedge clk_i) begin
    fault_o <= 1'b0;
  end
`endif

endmodule

`default_nettype wire
